fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: instruction-memory word-address width.
REQ-002 SHALL have parameter DEPTH, default 2: fetch-buffer entries; must be a power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: PC after reset; word aligned.
REQ-004 Clk  in  1  sole clock; all state changes on posedge.
REQ-005 Clrn  in  1  reset; asynchronous, active-low.
REQ-006 MEM_PCSrc  in  1  redirect request from MEM stage.
REQ-007 MEM_Btarg_or_Jtarg  in  32  redirect target address.
REQ-008 IMem_Addr  out  ADDR_W  word address to instruction memory, equal to PC[ADDR_W+1:2].
REQ-009 IMem_Data  in  32  instruction word; combinational read of IMem_Addr.
REQ-010 ID_Ready  in  1  decode accepts the head entry this cycle.
REQ-011 IFout_Valid  out  1  head entry valid.
REQ-012 IFout_PC / IFout_PC4 / IFout_Inst  out  32 each  head entry fields.
REQ-013 IFout_Misalign  out  1  misaligned-redirect flag.

Function
REQ-014 Fetch buffer SHALL be a FIFO of {PC, PC+4, Inst} with a count of $clog2(DEPTH)+1 bits.
REQ-015 Push SHALL occur when no redirect, state RUN, and (count<DEPTH or a pop occurs that cycle); push stores {PC, PC+4, IMem_Data}, then PC<=PC+4.
REQ-016 If no push occurs, PC SHALL hold.
REQ-017 Pop SHALL occur when IFout_Valid && ID_Ready && !MEM_PCSrc.
REQ-018 IFout_Valid SHALL equal (count!=0); head fields SHALL be driven 0 when count==0.
REQ-019 Latency: a word pushed into an empty buffer SHALL be visible on IFout_* the next cycle.
REQ-020 Full, no pop: SHALL neither push nor advance PC. Full with pop: push and pop in the same cycle; count unchanged.
REQ-021 Redirect (MEM_PCSrc=1) SHALL flush all entries, suppress push and pop, and load PC<=target. Redirect wins over any simultaneous pop or push.
REQ-022 After a redirect, IFout_Valid SHALL be 0 for one cycle; the target instruction SHALL be at the head on the second cycle.
REQ-023 PC+4 SHALL wrap modulo 2^32; IMem_Addr SHALL wrap modulo 2^ADDR_W.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 State machine SHALL have states RUN and HALT. The HALT state is reachable only with FETCH_MISALIGN_TRAP_EN (REQ-031).

Reset
REQ-026 On Clrn=0, SHALL immediately set: PC=RESET_PC, count=0, pointers=0, state=RUN, IFout_Misalign=0, IFout_Valid=0, head fields=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-028 The first push SHALL occur on the first posedge after Clrn deasserts.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-redirect handling.
REQ-030 Without the macro: target[1:0] SHALL be forced to 00 on redirect; IFout_Misalign SHALL be tied 0; state SHALL remain RUN.
REQ-031 With the macro, a redirect with target[1:0]!=0 SHALL:
- flush the buffer;
- load PC=target;
- enter HALT;
- set IFout_Misalign=1 (registered).
REQ-032 With the macro, HALT SHALL suppress all pushes.
REQ-033 With the macro, an aligned redirect SHALL return the state to RUN and clear IFout_Misalign. A misaligned redirect in HALT SHALL stay in HALT.

Structure
REQ-034 A shared package fetch_pkg SHALL hold:
- the state enum {RUN, HALT};
- the fetch-entry struct {pc, pc4, inst};
- the constant INST_W=32.
REQ-035 The FIFO SHALL be the sub-module fetch_buf, parameterised by DEPTH and entry width, with push, pop, flush and count ports.
REQ-036 The PC register and state machine SHALL reside in fetch_unit.

Verification
REQ-037 Reset release; ID_Ready=1; memory word n = 32'h1000_0000+n -> IFout_PC 0,4,8 on consecutive cycles, IFout_Inst 32'h1000_0000/1/2, Valid continuous from cycle 2.
REQ-038 DEPTH=2; ID_Ready=0 for 5 cycles -> count saturates at 2, PC holds at 8. Head stays PC=0 until ID_Ready=1, after which PC 0,4,8 drain in order.
REQ-039 Redirect to 32'h40 while full and ID_Ready=1 -> buffer flushed and no pop counted; Valid=0 one cycle; then head PC=32'h40, PC4=32'h44.
REQ-040 ADDR_W=5; fetch crosses PC=32'h7C -> IMem_Addr wraps 31->0 while IFout_PC4=32'h80.
REQ-041 With FETCH_MISALIGN_TRAP_EN, redirect to 32'h42 -> Misalign=1, Valid=0, no pushes. Then redirect to 32'h20 -> Misalign=0, head PC=32'h20 two cycles later.
REQ-042 Clrn pulsed low mid-stream with 2 entries buffered -> Valid=0 immediately; refetch starts from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, the buffered fetch entry and widths.
package fetch_pkg;

    localparam int INST_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] pc;
        logic [INST_W-1:0] pc4;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: power-of-two FIFO with flush; head is read combinationally so a word
// written into an empty buffer is visible on rd_data the following cycle.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, RUN/HALT control and a decoupling fetch buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects (HALT + IFout_Misalign).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              MEM_PCSrc,
    input  logic [31:0]       MEM_Btarg_or_Jtarg,
    output logic [ADDR_W-1:0] IMem_Addr,
    input  logic [31:0]       IMem_Data,
    input  logic              ID_Ready,
    output logic              IFout_Valid,
    output logic [31:0]       IFout_PC,
    output logic [31:0]       IFout_PC4,
    output logic [31:0]       IFout_Inst,
    output logic              IFout_Misalign
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]    pc_q, pc_d;
    logic [31:0]    pc_plus4;
    fetch_state_e   state_q, state_d;
    logic           push, pop;
    logic [CNT_W-1:0] count;
    fetch_entry_t   wr_entry, head;

    assign pc_plus4  = pc_q + 32'd4;
    assign IMem_Addr = pc_q[ADDR_W+1:2];

    // A redirect kills both sides of the buffer in the same cycle it flushes.
    assign pop  = IFout_Valid && ID_Ready && !MEM_PCSrc;
    assign push = !MEM_PCSrc && (state_q == RUN) && ((count < CNT_W'(DEPTH)) || pop);

    assign wr_entry.pc   = pc_q;
    assign wr_entry.pc4  = pc_plus4;
    assign wr_entry.inst = IMem_Data;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        misalign_d = misalign_q;
        if (MEM_PCSrc) begin
            pc_d = MEM_Btarg_or_Jtarg;
            if (MEM_Btarg_or_Jtarg[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                state_d    = RUN;
                misalign_d = 1'b0;
            end
        end else if (push) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    assign IFout_Misalign = misalign_q;
`else
    logic [1:0] unused_tgt_lo;
    assign unused_tgt_lo = MEM_Btarg_or_Jtarg[1:0];

    // Misaligned targets are silently word-aligned; the FSM never leaves RUN.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (MEM_PCSrc) begin
            pc_d = {MEM_Btarg_or_Jtarg[31:2], 2'b00};
        end else if (push) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign IFout_Misalign = 1'b0;
`endif

    fetch_buf #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_buf (
        .clk     (Clk),
        .rst_n   (Clrn),
        .push    (push),
        .pop     (pop),
        .flush   (MEM_PCSrc),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count)
    );

    assign IFout_Valid = (count != '0);
    assign IFout_PC    = IFout_Valid ? head.pc   : 32'h0;
    assign IFout_PC4   = IFout_Valid ? head.pc4  : 32'h0;
    assign IFout_Inst  = IFout_Valid ? head.inst : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected head entries,
// a negedge monitor compares them whenever decode accepts the head.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              Clk = 1'b0;
    logic              Clrn = 1'b0;
    logic              MEM_PCSrc = 1'b0;
    logic [31:0]       MEM_Btarg_or_Jtarg = 32'h0;
    logic [ADDR_W-1:0] IMem_Addr;
    logic [31:0]       IMem_Data;
    logic              ID_Ready = 1'b0;
    logic              IFout_Valid;
    logic [31:0]       IFout_PC, IFout_PC4, IFout_Inst;
    logic              IFout_Misalign;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .Clk                (Clk),
        .Clrn               (Clrn),
        .MEM_PCSrc          (MEM_PCSrc),
        .MEM_Btarg_or_Jtarg (MEM_Btarg_or_Jtarg),
        .IMem_Addr          (IMem_Addr),
        .IMem_Data          (IMem_Data),
        .ID_Ready           (ID_Ready),
        .IFout_Valid        (IFout_Valid),
        .IFout_PC           (IFout_PC),
        .IFout_PC4          (IFout_PC4),
        .IFout_Inst         (IFout_Inst),
        .IFout_Misalign     (IFout_Misalign)
    );

    // Memory word n holds 32'h1000_0000 + n.
    assign IMem_Data = 32'h1000_0000 + {{(32-ADDR_W){1'b0}}, IMem_Addr};

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst);
        fetch_entry_t e;
        e.pc   = pc;
        e.pc4  = pc + 32'd4;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    // Issues a one-cycle redirect, checks the bubble, returns with the target at the head.
    task automatic redirect(input logic [31:0] target);
        MEM_PCSrc          = 1'b1;
        MEM_Btarg_or_Jtarg = target;
        step();
        MEM_PCSrc = 1'b0;
        chk("redir_bubble_valid", {31'd0, IFout_Valid}, 32'd0);
        chk("redir_bubble_pc", IFout_PC, 32'd0);
        step();
        chk("redir_head_valid", {31'd0, IFout_Valid}, 32'd1);
        $display("redirect target=%h head_pc=%h", target, IFout_PC);
    endtask

    // Monitor: every accepted head entry is one transaction.
    always @(negedge Clk) begin : monitor
        fetch_entry_t e;
        if (Clrn && IFout_Valid && ID_Ready && !MEM_PCSrc) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no transaction", IFout_PC);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", IFout_PC, e.pc);
                chk("pop_pc4", IFout_PC4, e.pc4);
                chk("pop_inst", IFout_Inst, e.inst);
                $display("pop pc=%h pc4=%h inst=%h", IFout_PC, IFout_PC4, IFout_Inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_valid", {31'd0, IFout_Valid}, 32'd0);
        chk("rst_pc", IFout_PC, 32'd0);
        chk("rst_pc4", IFout_PC4, 32'd0);
        chk("rst_inst", IFout_Inst, 32'd0);
        chk("rst_misalign", {31'd0, IFout_Misalign}, 32'd0);
        chk("rst_imem_addr", {27'd0, IMem_Addr}, 32'd0);
        step();

        // Streaming from reset with decode always ready
        Clrn     = 1'b1;
        ID_Ready = 1'b1;
        expect_entry(32'h0, 32'h1000_0000);
        expect_entry(32'h4, 32'h1000_0001);
        expect_entry(32'h8, 32'h1000_0002);
        step();
        chk("first_push_valid", {31'd0, IFout_Valid}, 32'd1);
        chk("first_push_pc", IFout_PC, 32'h0);
        step();
        chk("stream_valid", {31'd0, IFout_Valid}, 32'd1);
        step();
        step();
        ID_Ready = 1'b0;
        step();
        chk("two_buffered_valid", {31'd0, IFout_Valid}, 32'd1);

        // Asynchronous reset mid-stream
        #2;
        Clrn = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, IFout_Valid}, 32'd0);
        chk("async_rst_pc", IFout_PC, 32'd0);
        chk("async_rst_imem_addr", {27'd0, IMem_Addr}, 32'd0);
        step();
        Clrn = 1'b1;

        // Back-pressure: buffer fills to DEPTH, PC holds at 8
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_head_pc", IFout_PC, 32'h0);
            chk("stall_valid", {31'd0, IFout_Valid}, 32'd1);
        end
        chk("stall_pc_hold", {27'd0, IMem_Addr}, 32'd2);
        expect_entry(32'h0, 32'h1000_0000);
        expect_entry(32'h4, 32'h1000_0001);
        expect_entry(32'h8, 32'h1000_0002);
        ID_Ready = 1'b1;
        step();
        step();
        step();

        // Redirect while full and ready: no pop, bubble, then target
        expect_entry(32'h40, 32'h1000_0010);
        redirect(32'h40);
        chk("redir_head_pc", IFout_PC, 32'h40);
        chk("redir_head_pc4", IFout_PC4, 32'h44);
        step();

        // IMem_Addr wrap across 0x7C
        expect_entry(32'h78, 32'h1000_001E);
        expect_entry(32'h7C, 32'h1000_001F);
        expect_entry(32'h80, 32'h1000_0000);
        redirect(32'h78);
        chk("wrap_addr_31", {27'd0, IMem_Addr}, 32'd31);
        step();
        chk("wrap_addr_0", {27'd0, IMem_Addr}, 32'd0);
        chk("wrap_pc4", IFout_PC4, 32'h80);
        step();
        step();
        ID_Ready = 1'b0;
        step();
        ID_Ready = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps into HALT
        MEM_PCSrc          = 1'b1;
        MEM_Btarg_or_Jtarg = 32'h42;
        step();
        MEM_PCSrc = 1'b0;
        chk("trap_misalign", {31'd0, IFout_Misalign}, 32'd1);
        chk("trap_valid", {31'd0, IFout_Valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("halt_valid", {31'd0, IFout_Valid}, 32'd0);
            chk("halt_pc_hold", {27'd0, IMem_Addr}, 32'd16);
            chk("halt_misalign", {31'd0, IFout_Misalign}, 32'd1);
        end
        expect_entry(32'h20, 32'h1000_0008);
        redirect(32'h20);
        chk("recover_misalign", {31'd0, IFout_Misalign}, 32'd0);
        chk("recover_head_pc", IFout_PC, 32'h20);
`else
        // Misaligned target is word-aligned without trapping
        expect_entry(32'h44, 32'h1000_0011);
        redirect(32'h46);
        chk("align_misalign", {31'd0, IFout_Misalign}, 32'd0);
        chk("align_head_pc", IFout_PC, 32'h44);
`endif
        step();
        ID_Ready = 1'b0;
        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
